rd_line_buf: RTL and testbench

RD_LINE_BUF -- requirements
Module: rd_line_buf

---
 rtl/rd_line_buf_if.sv | 43 ++++
 rtl/rd_line_buf.sv | 177 +++++++++++++++++
 tb/tb_rd_line_buf.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rd_line_buf_if.sv
// ============================================================================
// Module : rd_line_buf_if
// Brief  : Consumer, read-channel-manager and line-output signal bundle for
//          rd_line_buf.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rd_line_buf_if;
    logic         cpu_rd_req;
    logic [31:0]  cpu_rd_addr;
    logic         cpu_rd_ack;
    logic         rstart_rq;
    logic [31:0]  rin_addr;
    logic         rnext_rq;
    logic [3:0]   rnext_id;
    logic         rqfull_1;
    logic [127:0] rdat_m_data;
    logic         rdat_m_valid;
    logic         finish_mrd;
    logic         line_valid;
    logic         line_ready;
    logic [127:0] line_data;
    logic [31:0]  line_addr;
    logic [3:0]   line_id;
    logic         rlb_err;

    modport slave (
        input  cpu_rd_req, cpu_rd_addr, rnext_rq, rnext_id,
               rdat_m_data, rdat_m_valid, finish_mrd, line_ready,
        output cpu_rd_ack, rstart_rq, rin_addr, rqfull_1,
               line_valid, line_data, line_addr, line_id, rlb_err
    );

    modport master (
        output cpu_rd_req, cpu_rd_addr, rnext_rq, rnext_id,
               rdat_m_data, rdat_m_valid, finish_mrd, line_ready,
        input  cpu_rd_ack, rstart_rq, rin_addr, rqfull_1,
               line_valid, line_data, line_addr, line_id, rlb_err
    );
endinterface

`default_nettype wire

// File: rtl/rd_line_buf.sv
// ============================================================================
// Module : rd_line_buf
// Brief  : Credit-limited read line buffer pairing returned 128-bit lines with
//          their issue-order address/ID. Optional: RLB_ERR_STATUS_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rd_line_buf #(
    parameter int DEPTH = 4
) (
    input  wire logic     clk,
    input  wire logic     rst,
    rd_line_buf_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] c_DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_NEAR_FULL = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0] c_PTR_ONE   = PTR_W'(1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_NEXT = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic               w_ack, w_start;
    logic [27:0]        r_addr;
    logic [CNT_W-1:0]   r_credits, r_outstanding;

    logic [27:0]        r_tadr [DEPTH];
    logic [3:0]         r_tid  [DEPTH];
    logic [PTR_W-1:0]   r_twr, r_trd;
    logic [CNT_W-1:0]   r_tcnt, w_tcnt_nxt;

    logic [127:0]       r_dmem [DEPTH];
    logic [27:0]        r_dadr [DEPTH];
    logic [3:0]         r_did  [DEPTH];
    logic [PTR_W-1:0]   r_dwr, r_drd;
    logic [CNT_W-1:0]   r_dcnt, w_dcnt_nxt;
    logic               r_rqfull;

    logic               w_tempty, w_tfull, w_tpush, w_tpop;
    logic               w_dfull, w_dpush, w_pop, w_lv;
    logic [27:0]        w_head_adr;
    logic [3:0]         w_head_id;
    logic               w_unused;

    assign w_unused = ^bus.cpu_rd_addr[3:0];

    assign w_tempty   = (r_tcnt == '0);
    assign w_tfull    = (r_tcnt == c_DEPTH_CNT);
    assign w_tpop     = bus.rdat_m_valid && !w_tempty;
    assign w_tpush    = (r_state == WAIT_NEXT) && bus.rnext_rq && (!w_tfull || w_tpop);
    assign w_lv       = (r_dcnt != '0) && !rst;
    assign w_pop      = w_lv && bus.line_ready;
    assign w_dfull    = (r_dcnt == c_DEPTH_CNT);
    assign w_dpush    = bus.rdat_m_valid && (!w_dfull || w_pop);
    // A beat with no pending tag is still buffered, tagged with zeros
    assign w_head_adr = w_tempty ? '0 : r_tadr[r_trd];
    assign w_head_id  = w_tempty ? '0 : r_tid[r_trd];

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ack       = 1'b0;
        w_start     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.cpu_rd_req && (r_credits < c_DEPTH_CNT) && !rst) begin
                    w_ack       = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                w_start     = !rst;
                w_state_nxt = WAIT_NEXT;
            end
            WAIT_NEXT: begin
                if (bus.rnext_rq) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_tcnt_nxt = r_tcnt;
        if (w_tpush && !w_tpop)      w_tcnt_nxt = r_tcnt + c_CNT_ONE;
        else if (!w_tpush && w_tpop) w_tcnt_nxt = r_tcnt - c_CNT_ONE;
        w_dcnt_nxt = r_dcnt;
        if (w_dpush && !w_pop)       w_dcnt_nxt = r_dcnt + c_CNT_ONE;
        else if (!w_dpush && w_pop)  w_dcnt_nxt = r_dcnt - c_CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr        <= '0;
            r_credits     <= '0;
            r_outstanding <= '0;
            r_twr         <= '0;
            r_trd         <= '0;
            r_tcnt        <= '0;
            r_dwr         <= '0;
            r_drd         <= '0;
            r_dcnt        <= '0;
            r_rqfull      <= 1'b0;
        end else begin
            if (w_ack) r_addr <= bus.cpu_rd_addr[31:4];
            // Credits count accepted-but-not-yet-consumed lines
            if (w_ack && !(w_pop && r_credits != '0))
                r_credits <= r_credits + c_CNT_ONE;
            else if (!w_ack && w_pop && r_credits != '0)
                r_credits <= r_credits - c_CNT_ONE;
            if (w_ack && !(bus.finish_mrd && r_outstanding != '0))
                r_outstanding <= r_outstanding + c_CNT_ONE;
            else if (!w_ack && bus.finish_mrd && r_outstanding != '0)
                r_outstanding <= r_outstanding - c_CNT_ONE;
            if (w_tpush) r_twr <= r_twr + c_PTR_ONE;
            if (w_tpop)  r_trd <= r_trd + c_PTR_ONE;
            if (w_dpush) r_dwr <= r_dwr + c_PTR_ONE;
            if (w_pop)   r_drd <= r_drd + c_PTR_ONE;
            r_tcnt   <= w_tcnt_nxt;
            r_dcnt   <= w_dcnt_nxt;
            r_rqfull <= (w_dcnt_nxt >= c_NEAR_FULL);
        end
    end

    always_ff @(posedge clk) begin
        if (w_tpush) begin
            r_tadr[r_twr] <= r_addr;
            r_tid[r_twr]  <= bus.rnext_id;
        end
        if (w_dpush) begin
            r_dmem[r_dwr] <= bus.rdat_m_data;
            r_dadr[r_dwr] <= w_head_adr;
            r_did[r_dwr]  <= w_head_id;
        end
    end

    assign bus.cpu_rd_ack = w_ack;
    assign bus.rstart_rq  = w_start;
    assign bus.rin_addr   = rst ? 32'h0 : {r_addr, 4'h0};
    assign bus.rqfull_1   = r_rqfull;
    assign bus.line_valid = w_lv;
    assign bus.line_data  = w_lv ? r_dmem[r_drd] : '0;
    assign bus.line_addr  = w_lv ? {r_dadr[r_drd], 4'h0} : 32'h0;
    assign bus.line_id    = w_lv ? r_did[r_drd] : 4'h0;

`ifdef RLB_ERR_STATUS_EN
    logic r_err;
    logic w_err_evt;

    assign w_err_evt = (bus.rdat_m_valid && w_tempty)
                     || (bus.rdat_m_valid && w_dfull && !w_pop)
                     || (bus.rnext_rq && (r_state != WAIT_NEXT));

    always_ff @(posedge clk) begin
        if (rst)            r_err <= 1'b0;
        else if (w_err_evt) r_err <= 1'b1;
    end

    assign bus.rlb_err = r_err && !rst;
`else
    assign bus.rlb_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rd_line_buf.sv
// ============================================================================
// Module : tb_rd_line_buf
// Brief  : Directed self-checking bench for rd_line_buf (DEPTH=4).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rd_line_buf;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    rd_line_buf_if bus_if ();

    rd_line_buf #(.DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    function automatic logic [127:0] pat(input int k);
        logic [31:0] w;
        w = 32'hD000_0000 + 32'(k);
        return {4{w}};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [3:0] id, output bit acked);
        acked = 1'b0;
        bus_if.cpu_rd_req  = 1'b1;
        bus_if.cpu_rd_addr = a;
        #1;
        for (int i = 0; i < 4 && !acked; i++) begin
            if (bus_if.cpu_rd_ack) acked = 1'b1;
            else tick();
        end
        if (!acked) begin
            bus_if.cpu_rd_req = 1'b0;
            return;
        end
        tick();
        bus_if.cpu_rd_req = 1'b0;
        tick();
        bus_if.rnext_rq = 1'b1;
        bus_if.rnext_id = id;
        tick();
        bus_if.rnext_rq = 1'b0;
    endtask

    task automatic push_line(input logic [127:0] d);
        bus_if.rdat_m_valid = 1'b1;
        bus_if.rdat_m_data  = d;
        bus_if.finish_mrd   = 1'b1;
        tick();
        bus_if.rdat_m_valid = 1'b0;
        bus_if.finish_mrd   = 1'b0;
    endtask

    task automatic pop_line;
        bus_if.line_ready = 1'b1;
        tick();
        bus_if.line_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) tick();
        bus_if.cpu_rd_req  = 1'b1;
        bus_if.cpu_rd_addr = 32'h0000_1238;
        #1;
        checks++; if (bus_if.cpu_rd_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", bus_if.cpu_rd_ack); end
        checks++; if (bus_if.rstart_rq !== 1'b0) begin errors++; $display("FAIL reset_rstart: got %b expected 0", bus_if.rstart_rq); end
        checks++; if (bus_if.line_valid !== 1'b0) begin errors++; $display("FAIL reset_line_valid: got %b expected 0", bus_if.line_valid); end
        checks++; if (bus_if.rqfull_1 !== 1'b0) begin errors++; $display("FAIL reset_rqfull: got %b expected 0", bus_if.rqfull_1); end
        checks++; if (bus_if.rlb_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus_if.rlb_err); end
        checks++; if (bus_if.rin_addr !== 32'h0) begin errors++; $display("FAIL reset_rin_addr: got %h expected 0", bus_if.rin_addr); end
        checks++; if (bus_if.line_data !== 128'h0) begin errors++; $display("FAIL reset_line_data: got %h expected 0", bus_if.line_data); end
        bus_if.cpu_rd_req = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single;
        bus_if.cpu_rd_req  = 1'b1;
        bus_if.cpu_rd_addr = 32'h0000_1238;
        #1;
        checks++; if (bus_if.cpu_rd_ack !== 1'b1) begin errors++; $display("FAIL single_ack: got %b expected 1", bus_if.cpu_rd_ack); end
        tick();
        bus_if.cpu_rd_req = 1'b0;
        checks++; if (bus_if.rstart_rq !== 1'b1) begin errors++; $display("FAIL single_rstart: got %b expected 1", bus_if.rstart_rq); end
        checks++; if (bus_if.rin_addr !== 32'h0000_1230) begin errors++; $display("FAIL single_rin_addr: got %h expected 00001230", bus_if.rin_addr); end
        tick();
        checks++; if (bus_if.rstart_rq !== 1'b0) begin errors++; $display("FAIL single_rstart_pulse: got %b expected 0", bus_if.rstart_rq); end
        bus_if.rnext_rq = 1'b1;
        bus_if.rnext_id = 4'd3;
        tick();
        bus_if.rnext_rq = 1'b0;
        checks++; if (bus_if.line_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b expected 0", bus_if.line_valid); end
        push_line({16{8'hA5}});
        checks++; if (bus_if.line_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", bus_if.line_valid); end
        checks++; if (bus_if.line_addr !== 32'h0000_1230) begin errors++; $display("FAIL single_addr: got %h expected 00001230", bus_if.line_addr); end
        checks++; if (bus_if.line_id !== 4'd3) begin errors++; $display("FAIL single_id: got %h expected 3", bus_if.line_id); end
        checks++; if (bus_if.line_data !== {16{8'hA5}}) begin errors++; $display("FAIL single_data: got %h expected a5..a5", bus_if.line_data); end
        pop_line();
        checks++; if (bus_if.line_valid !== 1'b0) begin errors++; $display("FAIL single_drained: got %b expected 0", bus_if.line_valid); end
    endtask

    task automatic test_order;
        bit ok;
        logic [31:0] ea [3];
        ea = '{32'h100, 32'h200, 32'h300};
        for (int k = 0; k < 3; k++) begin
            issue(ea[k], 4'(k + 1), ok);
            checks++; if (ok !== 1'b1) begin errors++; $display("FAIL order_ack%0d: got %b expected 1", k, ok); end
        end
        for (int k = 0; k < 3; k++) push_line(pat(10 + k));
        checks++; if (bus_if.rqfull_1 !== 1'b1) begin errors++; $display("FAIL order_rqfull: got %b expected 1", bus_if.rqfull_1); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (bus_if.line_addr !== ea[k]) begin errors++; $display("FAIL order_addr%0d: got %h expected %h", k, bus_if.line_addr, ea[k]); end
            checks++; if (bus_if.line_id !== 4'(k + 1)) begin errors++; $display("FAIL order_id%0d: got %h expected %0d", k, bus_if.line_id, k + 1); end
            checks++; if (bus_if.line_data !== pat(10 + k)) begin errors++; $display("FAIL order_data%0d: got %h expected %h", k, bus_if.line_data, pat(10 + k)); end
            pop_line();
        end
        checks++; if (bus_if.line_valid !== 1'b0) begin errors++; $display("FAIL order_drained: got %b expected 0", bus_if.line_valid); end
    endtask

    task automatic test_fill;
        bit ok;
        bit seen;
        logic [31:0]  ea [4];
        logic [3:0]   ei [4];
        for (int k = 0; k < 4; k++) begin
            issue(32'h400 + 32'(k * 16), 4'(k + 4), ok);
            checks++; if (ok !== 1'b1) begin errors++; $display("FAIL fill_ack%0d: got %b expected 1", k, ok); end
        end
        push_line(pat(0));
        push_line(pat(1));
        checks++; if (bus_if.rqfull_1 !== 1'b0) begin errors++; $display("FAIL fill_rqfull_2: got %b expected 0", bus_if.rqfull_1); end
        push_line(pat(2));
        checks++; if (bus_if.rqfull_1 !== 1'b1) begin errors++; $display("FAIL fill_rqfull_3: got %b expected 1", bus_if.rqfull_1); end
        push_line(pat(3));
        checks++; if (bus_if.rqfull_1 !== 1'b1) begin errors++; $display("FAIL fill_rqfull_4: got %b expected 1", bus_if.rqfull_1); end
        // Fifth request must be held off while credits are exhausted
        bus_if.cpu_rd_req  = 1'b1;
        bus_if.cpu_rd_addr = 32'h500;
        #1;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (bus_if.cpu_rd_ack) seen = 1'b1;
            tick();
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL fill_holdoff: got ack %b expected 0", seen); end
        pop_line();
        #1;
        checks++; if (bus_if.cpu_rd_ack !== 1'b1) begin errors++; $display("FAIL fill_ack_after_pop: got %b expected 1", bus_if.cpu_rd_ack); end
        checks++; if (bus_if.line_addr !== 32'h410) begin errors++; $display("FAIL fill_head_after_pop: got %h expected 410", bus_if.line_addr); end
        tick();
        bus_if.cpu_rd_req = 1'b0;
        tick();
        bus_if.rnext_rq = 1'b1;
        bus_if.rnext_id = 4'd8;
        tick();
        bus_if.rnext_rq = 1'b0;
        push_line(pat(4));
        checks++; if (bus_if.rqfull_1 !== 1'b1) begin errors++; $display("FAIL fill_full: got %b expected 1", bus_if.rqfull_1); end
        // Push and pop together on a full FIFO
        bus_if.rdat_m_valid = 1'b1;
        bus_if.rdat_m_data  = pat(5);
        bus_if.line_ready   = 1'b1;
        tick();
        bus_if.rdat_m_valid = 1'b0;
        bus_if.line_ready   = 1'b0;
        checks++; if (bus_if.rqfull_1 !== 1'b1) begin errors++; $display("FAIL simul_rqfull: got %b expected 1", bus_if.rqfull_1); end
        ea = '{32'h420, 32'h430, 32'h500, 32'h0};
        ei = '{4'd6, 4'd7, 4'd8, 4'd0};
        for (int k = 0; k < 4; k++) begin
            checks++; if (bus_if.line_valid !== 1'b1) begin errors++; $display("FAIL simul_valid%0d: got %b expected 1", k, bus_if.line_valid); end
            checks++; if (bus_if.line_data !== pat(k + 2)) begin errors++; $display("FAIL simul_data%0d: got %h expected %h", k, bus_if.line_data, pat(k + 2)); end
            if (k < 3) begin
                checks++; if (bus_if.line_addr !== ea[k]) begin errors++; $display("FAIL simul_addr%0d: got %h expected %h", k, bus_if.line_addr, ea[k]); end
                checks++; if (bus_if.line_id !== ei[k]) begin errors++; $display("FAIL simul_id%0d: got %h expected %h", k, bus_if.line_id, ei[k]); end
            end
            pop_line();
        end
        checks++; if (bus_if.line_valid !== 1'b0) begin errors++; $display("FAIL simul_drained: got %b expected 0", bus_if.line_valid); end
    endtask

    task automatic test_back_to_back;
        bit ok;
        bit seen;
        issue(32'h600, 4'd9, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_first_ack: got %b expected 1", ok); end
        push_line(pat(20));
        // Accept and pop in the same cycle: credits must stay at one
        bus_if.cpu_rd_req  = 1'b1;
        bus_if.cpu_rd_addr = 32'h700;
        bus_if.line_ready  = 1'b1;
        #1;
        checks++; if (bus_if.cpu_rd_ack !== 1'b1) begin errors++; $display("FAIL b2b_ack_with_pop: got %b expected 1", bus_if.cpu_rd_ack); end
        tick();
        bus_if.cpu_rd_req = 1'b0;
        bus_if.line_ready = 1'b0;
        checks++; if (bus_if.line_valid !== 1'b0) begin errors++; $display("FAIL b2b_popped: got %b expected 0", bus_if.line_valid); end
        tick();
        bus_if.rnext_rq = 1'b1;
        bus_if.rnext_id = 4'd10;
        tick();
        bus_if.rnext_rq = 1'b0;
        push_line(pat(21));
        for (int k = 0; k < 3; k++) begin
            issue(32'h710 + 32'(k * 16), 4'(11 + k), ok);
            checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_ack%0d: got %b expected 1", k, ok); end
        end
        bus_if.cpu_rd_req  = 1'b1;
        bus_if.cpu_rd_addr = 32'h740;
        #1;
        seen = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (bus_if.cpu_rd_ack) seen = 1'b1;
            tick();
        end
        bus_if.cpu_rd_req = 1'b0;
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL b2b_credit_limit: got ack %b expected 0", seen); end
        push_line(pat(22));
    endtask

    task automatic test_reset_mid;
        push_line(pat(23));
        checks++; if (bus_if.rqfull_1 !== 1'b1) begin errors++; $display("FAIL rmid_pre_rqfull: got %b expected 1", bus_if.rqfull_1); end
        rst = 1'b1;
        bus_if.cpu_rd_req  = 1'b1;
        bus_if.cpu_rd_addr = 32'h808;
        #1;
        checks++; if (bus_if.cpu_rd_ack !== 1'b0) begin errors++; $display("FAIL rmid_ack_in_rst: got %b expected 0", bus_if.cpu_rd_ack); end
        tick();
        checks++; if (bus_if.line_valid !== 1'b0) begin errors++; $display("FAIL rmid_line_valid: got %b expected 0", bus_if.line_valid); end
        checks++; if (bus_if.rqfull_1 !== 1'b0) begin errors++; $display("FAIL rmid_rqfull: got %b expected 0", bus_if.rqfull_1); end
        rst = 1'b0;
        #1;
        checks++; if (bus_if.cpu_rd_ack !== 1'b1) begin errors++; $display("FAIL rmid_idle_ack: got %b expected 1", bus_if.cpu_rd_ack); end
        tick();
        bus_if.cpu_rd_req = 1'b0;
        checks++; if (bus_if.rin_addr !== 32'h800) begin errors++; $display("FAIL rmid_rin_addr: got %h expected 800", bus_if.rin_addr); end
        tick();
        bus_if.rnext_rq = 1'b1;
        bus_if.rnext_id = 4'd14;
        tick();
        bus_if.rnext_rq = 1'b0;
        push_line(pat(30));
        checks++; if (bus_if.line_addr !== 32'h800) begin errors++; $display("FAIL rmid_addr: got %h expected 800", bus_if.line_addr); end
        checks++; if (bus_if.line_id !== 4'd14) begin errors++; $display("FAIL rmid_id: got %h expected e", bus_if.line_id); end
        checks++; if (bus_if.line_data !== pat(30)) begin errors++; $display("FAIL rmid_data: got %h expected %h", bus_if.line_data, pat(30)); end
        pop_line();
        checks++; if (bus_if.line_valid !== 1'b0) begin errors++; $display("FAIL rmid_drained: got %b expected 0", bus_if.line_valid); end
    endtask

    task automatic test_error;
`ifdef RLB_ERR_STATUS_EN
        checks++; if (bus_if.rlb_err !== 1'b0) begin errors++; $display("FAIL err_initial: got %b expected 0", bus_if.rlb_err); end
        push_line(pat(40));
        checks++; if (bus_if.rlb_err !== 1'b1) begin errors++; $display("FAIL err_set: got %b expected 1", bus_if.rlb_err); end
        repeat (3) tick();
        checks++; if (bus_if.rlb_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", bus_if.rlb_err); end
        pop_line();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        checks++; if (bus_if.rlb_err !== 1'b0) begin errors++; $display("FAIL err_cleared: got %b expected 0", bus_if.rlb_err); end
`else
        push_line(pat(40));
        checks++; if (bus_if.rlb_err !== 1'b0) begin errors++; $display("FAIL err_disabled: got %b expected 0", bus_if.rlb_err); end
        pop_line();
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        rst                 = 1'b1;
        bus_if.cpu_rd_req   = 1'b0;
        bus_if.cpu_rd_addr  = 32'h0;
        bus_if.rnext_rq     = 1'b0;
        bus_if.rnext_id     = 4'h0;
        bus_if.rdat_m_data  = 128'h0;
        bus_if.rdat_m_valid = 1'b0;
        bus_if.finish_mrd   = 1'b0;
        bus_if.line_ready   = 1'b0;
        test_reset();
        test_single();
        test_order();
        test_fill();
        test_back_to_back();
        test_reset_mid();
        test_error();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
